// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser with an optional run-length stability filter.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4,
  parameter bit FILTER     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic line
);

  logic [1:0] sync;

  // Lines idle high, so the synchroniser resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], raw};
  end

  generate
    if (FILTER) begin : g_filt
      logic [3:0] cnt;
      logic       lvl;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
          lvl <= 1'b1;
        end else if (sync[1] == lvl) begin
          cnt <= '0;
        end else if (cnt == 4'(FILTER_LEN - 1)) begin
          lvl <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end

      assign line = lvl;
    end else begin : g_raw
      assign line = sync[1];
    end
  endgenerate

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: edge detect, 11-bit frame FSM, timeout, prefix folding.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       kbclk,
  input  logic       kbdata,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       brk,
  output logic       ext,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_f;
  logic          data_s;
  logic          clk_q;
  logic          fall;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          ext_pend;
  logic          brk_pend;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN),
    .FILTER    (1'b1)
  ) u_clk (
    .clk (clkin),
    .rst (rst),
    .raw (kbclk),
    .line(clk_f)
  );

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN),
    .FILTER    (1'b0)
  ) u_data (
    .clk (clkin),
    .rst (rst),
    .raw (kbdata),
    .line(data_s)
  );

  assign fall = clk_q & ~clk_f;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      clk_q      <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      code       <= '0;
      brk        <= 1'b0;
      ext        <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_q      <= clk_f;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        unique case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= data_s;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if ((^{shreg, par}) && data_s) begin
              unique case (1'b1)
                (shreg == PS2_PFX_EXT): ext_pend <= 1'b1;
                (shreg == PS2_PFX_BRK): brk_pend <= 1'b1;
                default: begin
                  code       <= shreg;
                  brk        <= brk_pend;
                  ext        <= ext_pend;
                  code_valid <= 1'b1;
                  ext_pend   <= 1'b0;
                  brk_pend   <= 1'b0;
                end
              endcase
            end else begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt      <= '0;
        state     <= IDLE;
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed self-checking bench for ps2_frame_rx.
module tb_ps2_frame_rx;

  localparam int T  = 300;
  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbclk = 1'b1;
  logic       kbdata = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       brk;
  logic       ext;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int nv    = 0;
  int ne    = 0;
  int both  = 0;
  int v0;
  int e0;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(T),
    .FILTER_LEN    (FL)
  ) dut (
    .clkin     (clk),
    .rst       (rst),
    .kbclk     (kbclk),
    .kbdata    (kbdata),
    .code      (code),
    .code_valid(code_valid),
    .brk       (brk),
    .ext       (ext),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) nv <= nv + 1;
    if (frame_err) ne <= ne + 1;
    if (code_valid && frame_err) both <= both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    kbdata = b;
    repeat (10) @(negedge clk);
    kbclk = 1'b0;
    repeat (20) @(negedge clk);
    kbclk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ flip);
    send_bit(1'b1);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] c,
                         input logic bk, input logic ex);
    chk({tag, "_nv"}, nv - v0, 1);
    chk({tag, "_ne"}, ne - e0, 0);
    chk({tag, "_code"}, code, c);
    chk({tag, "_brk"}, brk, bk);
    chk({tag, "_ext"}, ext, ex);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_code", code, 0);
    chk("rst_cv", code_valid, 0);
    chk("rst_brk", brk, 0);
    chk("rst_ext", ext, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    v0 = nv; e0 = ne;
    send_frame(8'h16, 1'b0);
    chk_out("make16", 8'h16, 1'b0, 1'b0);

    v0 = nv; e0 = ne;
    send_frame(8'hF0, 1'b0);
    chk("f0_nostrobe", nv - v0, 0);
    send_frame(8'h16, 1'b0);
    chk_out("brk16", 8'h16, 1'b1, 1'b0);

    v0 = nv; e0 = ne;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk_out("extbrk75", 8'h75, 1'b1, 1'b1);

    v0 = nv; e0 = ne;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h16, 1'b1);
    chk("par_ne", ne - e0, 1);
    chk("par_nv", nv - v0, 0);
    e0 = ne;
    send_frame(8'h1E, 1'b0);
    chk_out("after_par", 8'h1E, 1'b0, 1'b0);

    v0 = nv; e0 = ne;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    kbdata = 1'b0;
    repeat (10) @(negedge clk);
    kbclk = 1'b0;
    repeat (6 + T) @(posedge clk);
    #1 chk("to_early", frame_err, 0);
    @(posedge clk);
    #1 chk("to_hit", frame_err, 1);
    @(posedge clk);
    #1 chk("to_pulse", frame_err, 0);
    @(negedge clk);
    kbclk = 1'b1;
    repeat (20) @(negedge clk);
    chk("to_ne", ne - e0, 1);
    chk("to_nv", nv - v0, 0);
    e0 = ne;
    send_frame(8'h45, 1'b0);
    chk_out("after_to", 8'h45, 1'b0, 1'b0);

    v0 = nv; e0 = ne;
    kbdata = 1'b1;
    @(negedge clk);
    kbclk = 1'b0;
    repeat (2) @(negedge clk);
    kbclk = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_ne", ne - e0, 0);
    chk("glitch_nv", nv - v0, 0);

    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_code", code, 0);
    chk("mid_cv", code_valid, 0);
    chk("mid_brk", brk, 0);
    chk("mid_ext", ext, 0);
    chk("mid_ferr", frame_err, 0);
    rst = 1'b0;
    e0 = ne;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (T + 20) @(negedge clk);
    chk("abort_ne", ne - e0, 3);
    chk("abort_nv", nv - v0, 0);
    e0 = ne;
    send_frame(8'h1C, 1'b0);
    chk_out("fresh1c", 8'h1C, 1'b0, 1'b0);

    chk("never_both", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
